// File: rtl/ram_arb_ctrl_if.sv
// Requester and RAM-side signal bundle for ram_arb_ctrl.
// slave is the arbiter's view of the bundle; master is the environment's view.
interface ram_arb_ctrl_if #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 8
);
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          gnt0;
    logic [DW-1:0] rdata0;
    logic          rvalid0;

    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          gnt1;
    logic [DW-1:0] rdata1;
    logic          rvalid1;

    logic          init_done;
    logic          ram_cs;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    modport slave (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, ram_dout,
        output gnt0, rdata0, rvalid0, gnt1, rdata1, rvalid1,
        output init_done, ram_cs, ram_we, ram_addr, ram_din
    );

    modport master (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, ram_dout,
        input  gnt0, rdata0, rvalid0, gnt1, rdata1, rvalid1,
        input  init_done, ram_cs, ram_we, ram_addr, ram_din
    );
endinterface

// File: rtl/ram_arb_ctrl.sv
// Two-port round-robin arbiter/sequencer for a single-port synchronous RAM.
// Zeroes the whole RAM after reset, then serves one CS/WE access per grant.
module ram_arb_ctrl #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 8
) (
    input logic           clk,
    input logic           rst,
    ram_arb_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StClear, StIdle, StIssue, StRdata} state_e;

    state_e        state_q, state_d;
    logic [AW:0]   clr_cnt_q, clr_cnt_d;
    logic          last_q, last_d;
    logic          sel_q, sel_d;
    logic          we_q, we_d;
    logic          gnt0_q, gnt0_d;
    logic          gnt1_q, gnt1_d;
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic          init_done_q, init_done_d;
    logic          ram_cs_q, ram_cs_d;
    logic          ram_we_q, ram_we_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_din_q, ram_din_d;

    logic pick;

    // On contention the port that did not win last time goes next.
    assign pick = (bus.req0 && bus.req1) ? ~last_q : bus.req1;

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        last_d      = last_q;
        sel_d       = sel_q;
        we_d        = we_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        rvalid0_d   = 1'b0;
        rvalid1_d   = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        init_done_d = init_done_q;
        ram_cs_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;

        case (state_q)
            StClear: begin
                // Counter MSB set means every location has been written.
                if (clr_cnt_q[AW]) begin
                    init_done_d = 1'b1;
                    state_d     = StIdle;
                end else begin
                    ram_cs_d   = 1'b1;
                    ram_we_d   = 1'b1;
                    ram_addr_d = clr_cnt_q[AW-1:0];
                    ram_din_d  = '0;
                    clr_cnt_d  = clr_cnt_q + (AW+1)'(1);
                end
            end
            StIdle: begin
                if (bus.req0 || bus.req1) begin
                    sel_d      = pick;
                    last_d     = pick;
                    we_d       = pick ? bus.we1 : bus.we0;
                    gnt0_d     = ~pick;
                    gnt1_d     = pick;
                    ram_cs_d   = 1'b1;
                    ram_we_d   = pick ? bus.we1 : bus.we0;
                    ram_addr_d = pick ? bus.addr1 : bus.addr0;
                    ram_din_d  = pick ? bus.wdata1 : bus.wdata0;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                state_d = we_q ? StIdle : StRdata;
            end
            StRdata: begin
                if (sel_q) begin
                    rdata1_d  = bus.ram_dout;
                    rvalid1_d = 1'b1;
                end else begin
                    rdata0_d  = bus.ram_dout;
                    rvalid0_d = 1'b1;
                end
                state_d = StIdle;
            end
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StClear;
            clr_cnt_q   <= '0;
            last_q      <= 1'b1;
            sel_q       <= 1'b0;
            we_q        <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            init_done_q <= 1'b0;
            ram_cs_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            last_q      <= last_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            init_done_q <= init_done_d;
            ram_cs_q    <= ram_cs_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
        end
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.rvalid0   = rvalid0_q;
    assign bus.rvalid1   = rvalid1_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
    assign bus.init_done = init_done_q;
    assign bus.ram_cs    = ram_cs_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_din   = ram_din_q;
endmodule

// File: tb/tb_ram_arb_ctrl.sv
// Bench for ram_arb_ctrl: directed table plus corner sequences, then random traffic
// checked against a transaction-level memory/fairness model.
module tb_ram_arb_ctrl;
    localparam int AW = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_arb_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    ram_arb_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Behavioural RAM, preloaded with non-zero junk so the clear sweep is observable.
    logic [DW-1:0] ram_mem [16];
    logic          mem_primed = 1'b0;
    always @(posedge clk) begin
        if (!mem_primed) begin
            for (int i = 0; i < 16; i++) ram_mem[i] <= 8'hA5 ^ 8'(i);
            mem_primed <= 1'b1;
        end else if (bus.ram_cs) begin
            if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_din;
            else            bus.ram_dout <= ram_mem[bus.ram_addr];
        end
    end

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] exp_rd [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic gnt_of(input int p);
        return (p == 0) ? bus.gnt0 : bus.gnt1;
    endfunction
    function automatic logic rv_of(input int p);
        return (p == 0) ? bus.rvalid0 : bus.rvalid1;
    endfunction
    function automatic logic [DW-1:0] rd_of(input int p);
        return (p == 0) ? bus.rdata0 : bus.rdata1;
    endfunction
    function automatic logic [63:0] all_outs();
        return 64'({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.rdata0, bus.rdata1,
                    bus.init_done, bus.ram_cs, bus.ram_we, bus.ram_addr, bus.ram_din});
    endfunction

    task automatic set_req(input int p, input logic r, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        #1;
        chk("reset_outputs", all_outs(), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
    endtask

    task automatic wait_init();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.init_done && n < 40);
        chk("init_done", bus.init_done, 1);
    endtask

    task automatic wait_gnt(input int p, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!gnt_of(p) && n < 40);
        chk(name, gnt_of(p), 1);
    endtask

    // One command on port p; reads are checked for latency, data and the other port's rdata.
    task automatic do_cmd(input int p, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] exp, input string name);
        set_req(p, 1'b1, we, a, d);
        wait_gnt(p, {name, "_gnt"});
        set_req(p, 1'b0, we, a, d);
        @(negedge clk);
        chk({name, "_gnt_pulse"}, gnt_of(p), 0);
        chk({name, "_cs_off"}, bus.ram_cs, 0);
        if (!we) begin
            chk({name, "_rvalid_early"}, rv_of(p), 0);
            @(negedge clk);
            chk({name, "_rvalid"}, rv_of(p), 1);
            chk({name, "_rdata"}, rd_of(p), exp);
            exp_rd[p] = exp;
            @(negedge clk);
            chk({name, "_rvalid_pulse"}, rv_of(p), 0);
        end
        chk({name, "_rdata_other"}, rd_of(1 - p), exp_rd[1 - p]);
    endtask

    typedef struct {
        int            p;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp;
    } vec_t;

    typedef struct {
        int            due;
        logic [DW-1:0] d;
    } rd_t;

    rd_t rq0[$];
    rd_t rq1[$];

    task automatic rv_check(input int p, input int cyc);
        logic have;
        rd_t  e;
        have = 1'b0;
        e.due = 0;
        e.d = '0;
        if (p == 0 && rq0.size() > 0 && rq0[0].due == cyc) begin
            e = rq0.pop_front();
            have = 1'b1;
        end
        if (p == 1 && rq1.size() > 0 && rq1[0].due == cyc) begin
            e = rq1.pop_front();
            have = 1'b1;
        end
        chk("rnd_rvalid", rv_of(p), have);
        if (have) chk("rnd_rdata", rd_of(p), e.d);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          vecs [8];
        int            seq [4];
        int            ng;
        int            n;
        int            last_g;
        logic [DW-1:0] ref_mem [16];
        logic          pend [2];
        logic          pwe [2];
        logic [AW-1:0] paddr [2];
        int            wait_c [2];
        int            last_win;
        logic          g [2];

        vecs[0] = '{1, 1'b1, 4'd2,  8'h5A, 8'h00};
        vecs[1] = '{0, 1'b0, 4'd2,  8'h00, 8'h5A};
        vecs[2] = '{1, 1'b0, 4'd9,  8'h00, 8'h0C};
        vecs[3] = '{0, 1'b1, 4'd15, 8'hF0, 8'h00};
        vecs[4] = '{1, 1'b0, 4'd15, 8'h00, 8'hF0};
        vecs[5] = '{0, 1'b0, 4'd0,  8'h00, 8'h00};
        vecs[6] = '{1, 1'b1, 4'd0,  8'h11, 8'h00};
        vecs[7] = '{0, 1'b0, 4'd0,  8'h00, 8'h11};

        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);

        // Clear sweep: 16 write cycles, addresses 0..15, then init_done.
        do_reset();
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("clear_cycle", {bus.init_done, bus.ram_cs, bus.ram_we, bus.ram_addr, bus.ram_din},
                {1'b0, 1'b1, 1'b1, 4'(k), 8'h00});
        end
        @(negedge clk);
        chk("clear_end", {bus.init_done, bus.ram_cs}, 2'b10);
        do_cmd(0, 1'b0, 4'd9, 8'h00, 8'h00, "rd0_after_clear");

        do_cmd(0, 1'b1, 4'd9, 8'h0C, 8'h00, "wr0_a9");
        do_cmd(0, 1'b0, 4'd9, 8'h00, 8'h0C, "rd0_a9");

        for (int i = 0; i < 8; i++)
            do_cmd(vecs[i].p, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp, "table");

        // Continuous contention must alternate, port 0 first after reset.
        do_reset();
        wait_init();
        set_req(0, 1'b1, 1'b1, 4'd0, 8'h03);
        set_req(1, 1'b1, 1'b1, 4'd1, 8'h04);
        ng = 0;
        for (int c = 0; c < 30 && ng < 4; c++) begin
            @(negedge clk);
            chk("contend_excl", bus.gnt0 & bus.gnt1, 0);
            if (bus.gnt0 || bus.gnt1) begin
                seq[ng] = bus.gnt1 ? 1 : 0;
                ng++;
            end
            if (ng == 4) begin
                set_req(0, 1'b0, 1'b1, 4'd0, 8'h03);
                set_req(1, 1'b0, 1'b1, 4'd1, 8'h04);
            end
        end
        chk("contend_count", ng, 4);
        for (int i = 0; i < ng; i++) chk("contend_order", seq[i], i % 2);
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        do_cmd(0, 1'b0, 4'd0, 8'h00, 8'h03, "contend_rd0");
        do_cmd(1, 1'b0, 4'd1, 8'h00, 8'h04, "contend_rd1");

        // Lone port 1 streaming writes: a grant every second cycle.
        set_req(1, 1'b1, 1'b1, 4'd0, 8'h03);
        n = 0;
        last_g = 0;
        for (int c = 0; c < 80 && n < 16; c++) begin
            @(negedge clk);
            if (bus.gnt1) begin
                if (n > 0) chk("stream_gap", c - last_g, 2);
                last_g = c;
                n++;
                if (n == 16) set_req(1, 1'b0, 1'b0, '0, '0);
                else set_req(1, 1'b1, 1'b1, 4'(n), 8'(3 + n));
            end
        end
        chk("stream_count", n, 16);
        do_cmd(1, 1'b0, 4'd15, 8'h00, 8'h12, "stream_rd15");
        do_cmd(1, 1'b0, 4'd0, 8'h00, 8'h03, "stream_rd0");

        // Reset while a write is in ISSUE: the write never lands.
        set_req(0, 1'b1, 1'b1, 4'd5, 8'hAA);
        wait_gnt(0, "rst_mid_gnt");
        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, '0, '0);
        #1;
        chk("rst_mid_outputs", all_outs(), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        wait_init();
        do_cmd(0, 1'b0, 4'd5, 8'h00, 8'h00, "rst_mid_rd5");

        // Request held through the whole sweep.
        @(negedge clk);
        rst = 1'b1;
        set_req(1, 1'b0, 1'b0, '0, '0);
        set_req(0, 1'b1, 1'b0, 4'd3, 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            chk("hold_no_gnt", bus.gnt0, 0);
        end while (!bus.init_done && n < 40);
        chk("hold_init_edge", n, 17);
        @(negedge clk);
        chk("hold_first_gnt", bus.gnt0, 1);
        set_req(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("hold_rvalid_early", bus.rvalid0, 0);
        @(negedge clk);
        chk("hold_rvalid", bus.rvalid0, 1);
        chk("hold_rdata", bus.rdata0, 0);

        // Random two-port traffic against a memory/fairness model.
        do_reset();
        wait_init();
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        last_win = 1;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0;
            pwe[p] = 1'b0;
            paddr[p] = '0;
            wait_c[p] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            g[0] = bus.gnt0;
            g[1] = bus.gnt1;
            if (g[0] || g[1]) chk("rnd_gnt_excl", g[0] & g[1], 0);
            for (int p = 0; p < 2; p++) begin
                if (g[p]) begin
                    chk("rnd_gnt_owner", pend[p], 1);
                    if (pend[0] && pend[1]) chk("rnd_gnt_rr", p, 1 - last_win);
                    last_win = p;
                    pend[p] = 1'b0;
                    wait_c[p] = 0;
                    if (pwe[p]) begin
                        ref_mem[paddr[p]] = (p == 0) ? bus.wdata0 : bus.wdata1;
                    end else if (p == 0) begin
                        rq0.push_back('{cyc + 2, ref_mem[paddr[p]]});
                    end else begin
                        rq1.push_back('{cyc + 2, ref_mem[paddr[p]]});
                    end
                end
            end
            for (int p = 0; p < 2; p++) begin
                rv_check(p, cyc);
                if (pend[p]) begin
                    wait_c[p]++;
                    chk("rnd_wait_bound", wait_c[p] <= 8, 1);
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (cyc >= 2990) begin
                    pend[p] = 1'b0;
                    set_req(p, 1'b0, 1'b0, '0, '0);
                end else if (!pend[p] && $urandom_range(0, 2) != 0) begin
                    pend[p] = 1'b1;
                    pwe[p] = 1'($urandom_range(0, 1));
                    paddr[p] = 4'($urandom_range(0, 15));
                    set_req(p, 1'b1, pwe[p], paddr[p], 8'($urandom_range(0, 255)));
                end else if (!pend[p]) begin
                    set_req(p, 1'b0, 1'b0, '0, '0);
                end
            end
        end
        chk("rnd_drain0", rq0.size(), 0);
        chk("rnd_drain1", rq1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
